// File: rtl/number_input_if.sv
// Button/switch entry bus for number_input: raw inputs in, submitted value out.
interface number_input_if;
  logic       btn;
  logic [7:0] sw;
  logic       next;
  logic [7:0] number;
  logic [7:0] count;
  logic       overflow;

  modport master (output btn, sw, input next, number, count, overflow);
  modport slave  (input btn, sw, output next, number, count, overflow);
endinterface

// File: rtl/number_input.sv
// Debounced push-button entry of an 8-bit switch value with a saturating submit count.
// Define NUMBER_INPUT_DEBOUNCE_EN to enable the DB_HI/DB_LO debounce states and counter.
//
// state | meaning
// IDLE  | button released and stable
// DB_HI | button seen high, waiting DB_CYCLES for it to stay high
// HELD  | press accepted, waiting for release
// DB_LO | button seen low while held, waiting DB_CYCLES for it to stay low
module number_input #(
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  number_input_if.slave bus
);

  if (DB_CYCLES < 2 || DB_CYCLES > (1 << 24)) begin : g_bad_cfg
    $error("number_input: DB_CYCLES must be in 2..2**24");
  end

  typedef enum logic [1:0] {IDLE, DB_HI, HELD, DB_LO} state_t;

  state_t     state, state_nxt;
  logic       accept;
  logic       btn_m, btn_s;
  logic [7:0] sw_m, sw_s;
  logic       next_r;
  logic [7:0] number_r, count_r;
  logic       overflow_r;

`ifdef NUMBER_INPUT_DEBOUNCE_EN
  localparam logic [23:0] CNT_LAST = 24'(DB_CYCLES - 1);
  logic [23:0] cnt, cnt_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= bus.btn;
      btn_s <= btn_m;
      sw_m  <= bus.sw;
      sw_s  <= sw_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef NUMBER_INPUT_DEBOUNCE_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nxt;
`ifdef NUMBER_INPUT_DEBOUNCE_EN
      cnt   <= cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
`ifdef NUMBER_INPUT_DEBOUNCE_EN
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = DB_HI;
          cnt_nxt   = '0;
        end
      end
      DB_HI: begin
        if (!btn_s) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_nxt = DB_LO;
          cnt_nxt   = '0;
        end
      end
      DB_LO: begin
        // a high sample here is the same press still bouncing, not a new one
        if (btn_s) begin
          state_nxt = HELD;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
`else
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_nxt = HELD;
          accept    = 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      next_r     <= 1'b0;
      number_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      next_r <= 1'b0;
      if (accept) begin
        if (count_r == 8'hFF) begin
          overflow_r <= 1'b1;
        end else begin
          next_r   <= 1'b1;
          number_r <= sw_s;
          count_r  <= count_r + 8'd1;
        end
      end
    end
  end

  assign bus.next     = next_r;
  assign bus.number   = number_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_number_input.sv
// Self-checking bench for number_input: directed timing/overflow/reset cases plus random
// bounce trains compared every cycle against a run-length reference model.
module tb_number_input;

`ifdef NUMBER_INPUT_DEBOUNCE_EN
  localparam bit DEBOUNCE = 1'b1;
`else
  localparam bit DEBOUNCE = 1'b0;
`endif
  localparam int DB      = 4;
  localparam int LAT     = DEBOUNCE ? DB + 2 : 2;
  localparam int THRESH  = DEBOUNCE ? DB + 1 : 1;
  localparam int PRE_RST = DEBOUNCE ? 3 : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  number_input_if bus ();

  number_input #(.DB_CYCLES(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulses = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: the FSM sees btn/sw as sampled two edges earlier. The debounced level flips
  // once the opposite value has been seen THRESH samples in a row; a flip to 1 is a press.
  logic       h_b0, h_b1;
  logic [7:0] h_s0, h_s1;
  logic       m_level, m_next, m_ovf;
  int         m_run;
  logic [7:0] m_number, m_count;

  always @(posedge clk) begin
    if (rst) begin
      h_b0 = 0; h_b1 = 0; h_s0 = 0; h_s1 = 0;
      m_level = 0; m_run = 0; m_next = 0; m_ovf = 0; m_number = 0; m_count = 0;
    end else begin
      m_next = 0;
      if (h_b1 == m_level) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == THRESH) begin
          m_level = h_b1;
          m_run   = 0;
          if (h_b1) begin
            if (m_count == 8'd255) m_ovf = 1;
            else begin
              m_next   = 1;
              m_number = h_s1;
              m_count  = m_count + 8'd1;
            end
          end
        end
      end
      h_b1 = h_b0; h_s1 = h_s0;
      h_b0 = bus.btn; h_s0 = bus.sw;
    end
  end

  always @(negedge clk) begin
    check_eq("m_next", bus.next, m_next);
    check_eq("m_number", bus.number, m_number);
    check_eq("m_count", bus.count, m_count);
    check_eq("m_overflow", bus.overflow, m_ovf);
    if (bus.next === 1'b1) n_pulses++;
  end

  // Called at a negedge; drives btn for n cycles.
  task automatic hold(input logic b, input int n);
    bus.btn = b;
    repeat (n) @(negedge clk);
  endtask

  // btn has just gone (or stays) high; edge i=0 is the first edge sampling it.
  task automatic expect_pulse(input string tag);
    for (int i = 0; i <= LAT + 1; i++) begin
      @(posedge clk);
      #1;
      check_eq(tag, bus.next, (i == LAT) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
  endtask

  int  p0, len;
  bit  v;

  initial begin
    bus.btn = 0;
    bus.sw  = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    check_eq("rst_next", bus.next, 0);
    check_eq("rst_count", bus.count, 0);
    check_eq("rst_number", bus.number, 0);
    check_eq("rst_ovf", bus.overflow, 0);

    // stable press latency
    bus.sw  = 8'h2A;
    bus.btn = 1;
    expect_pulse("press_lat");
    check_eq("press_number", bus.number, 8'h2A);
    check_eq("press_count", bus.count, 1);
    bus.sw = 8'h55;
    hold(0, 12);
    check_eq("number_hold", bus.number, 8'h2A);

    // short toggles
    p0 = n_pulses;
    hold(1, 1); hold(0, 1); hold(1, 1); hold(0, 12);
    check_eq("toggle_pulses", n_pulses - p0, DEBOUNCE ? 0 : 2);
    check_eq("toggle_count", bus.count, DEBOUNCE ? 1 : 3);

    // release glitch while held
    p0 = n_pulses;
    bus.sw = 8'hC3;
    hold(1, 10); hold(0, 2); hold(1, 10); hold(0, 12);
    check_eq("glitch_pulses", n_pulses - p0, DEBOUNCE ? 1 : 2);
    check_eq("glitch_number", bus.number, 8'hC3);

    // random bounce trains with occasional resets
    v = 0;
    for (int seg = 0; seg < 80; seg++) begin
      v = ~v;
      len = $urandom_range(1, 8);
      bus.btn = v;
      for (int c = 0; c < len; c++) begin
        bus.sw = 8'($urandom);
        rst = ($urandom_range(0, 39) == 0);
        @(negedge clk);
      end
      rst = 0;
    end
    hold(0, 12);

    // reset mid-debounce, button still held afterwards
    bus.sw  = 8'h77;
    bus.btn = 1;
    repeat (PRE_RST) @(negedge clk);
    p0  = n_pulses;
    rst = 1;
    @(posedge clk);
    #1;
    check_eq("rst_mid_next", bus.next, 0);
    check_eq("rst_mid_count", bus.count, 0);
    check_eq("rst_mid_number", bus.number, 0);
    check_eq("rst_mid_ovf", bus.overflow, 0);
    @(negedge clk);
    check_eq("rst_mid_pulses", n_pulses - p0, 0);
    rst = 0;
    expect_pulse("rst_relat");
    check_eq("rst_re_count", bus.count, 1);
    check_eq("rst_re_number", bus.number, 8'h77);
    hold(0, 12);

    // saturation sweep
    rst = 1;
    @(negedge clk);
    rst = 0;
    p0 = n_pulses;
    for (int i = 0; i < 255; i++) begin
      bus.sw = 8'(i);
      hold(1, 7);
      hold(0, 8);
    end
    check_eq("sweep_count", bus.count, 255);
    check_eq("sweep_pulses", n_pulses - p0, 255);
    check_eq("sweep_ovf_pre", bus.overflow, 0);
    bus.sw = 8'hFF;
    hold(1, 7);
    hold(0, 8);
    check_eq("sweep_ovf", bus.overflow, 1);
    check_eq("sweep_count_sat", bus.count, 255);
    check_eq("sweep_number", bus.number, 254);
    check_eq("sweep_pulses_sat", n_pulses - p0, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
